// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared datapath widths and types used by decode, ALU,
//               writeback and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int c_data_w = 16;
    localparam int c_addr_w = 3;
    localparam int c_num_regs = 1 << c_addr_w;

    typedef logic [c_addr_w-1:0] reg_addr_t;
    typedef logic [c_data_w-1:0] word_t;

    // Value loaded into a register by the bring-up init strobe.
    function automatic word_t index_word(input reg_addr_t idx);
        return word_t'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Read/write port bundle between decode/writeback and the
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int N = c_data_w,
    parameter int M = c_addr_w
);

    logic         Reg_Write;
    logic [M-1:0] Reg_write_ad;
    logic [N-1:0] Reg_write_data;
    logic [M-1:0] Reg_read_ad_1;
    logic [M-1:0] Reg_read_ad_2;
    logic         inr_check;
    logic [N-1:0] Reg_read_data_1;
    logic [N-1:0] Reg_read_data_2;

    modport master (
        output Reg_Write,
        output Reg_write_ad,
        output Reg_write_data,
        output Reg_read_ad_1,
        output Reg_read_ad_2,
        output inr_check,
        input  Reg_read_data_1,
        input  Reg_read_data_2
    );

    modport slave (
        input  Reg_Write,
        input  Reg_write_ad,
        input  Reg_write_data,
        input  Reg_read_ad_1,
        input  Reg_read_ad_2,
        input  inr_check,
        output Reg_read_data_1,
        output Reg_read_data_2
    );

endinterface
`default_nettype wire

// File: rtl/register_file_read_mux.sv
`default_nettype none
// ============================================================================
// Module      : register_file_read_mux
// Description : 2^M:1 N-bit combinational read selector.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_read_mux
    import register_file_pkg::*;
#(
    parameter int N = c_data_w,
    parameter int M = c_addr_w
) (
    input  wire logic [N-1:0] i_regs [1 << M],
    input  wire logic [M-1:0] i_sel,
    output logic      [N-1:0] o_data
);

    assign o_data = i_regs[i_sel];

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 2^M x N register file, two combinational read ports, one
//               synchronous write port, synchronous clear and index-init.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import register_file_pkg::*;
#(
    parameter int N = c_data_w,
    parameter int M = c_addr_w
) (
    input wire logic        Clock,
    input wire logic        Reset,
    register_file_if.slave  bus
);

    localparam int c_regs = 1 << M;

    // The init strobe stores each register's own index, so it must fit in N bits.
    generate
        if (M < 1) begin : g_bad_addr_w
            $error("register_file: M must be at least 1");
        end
        if (N < M) begin : g_bad_data_w
            $error("register_file: N must be at least M");
        end
    endgenerate

    logic [N-1:0] r_regs [c_regs];

    // Priority: clear, then index-init, then the write port.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < c_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.inr_check) begin
            for (int i = 0; i < c_regs; i++) begin
                r_regs[i] <= N'(i);
            end
        end else if (bus.Reg_Write) begin
            r_regs[bus.Reg_write_ad] <= bus.Reg_write_data;
        end
    end

    register_file_read_mux #(
        .N (N),
        .M (M)
    ) u_read_mux_1 (
        .i_regs (r_regs),
        .i_sel  (bus.Reg_read_ad_1),
        .o_data (bus.Reg_read_data_1)
    );

    register_file_read_mux #(
        .N (N),
        .M (M)
    ) u_read_mux_2 (
        .i_regs (r_regs),
        .i_sel  (bus.Reg_read_ad_2),
        .o_data (bus.Reg_read_data_2)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed plus randomized checks of register_file against an
//               array model of the register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int N = 16;
    localparam int M = 3;
    localparam int R = 1 << M;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [N-1:0] mdl [R];

    register_file_if #(.N(N), .M(M)) bus ();

    register_file #(
        .N (N),
        .M (M)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; the model applies the documented priority to the inputs held there.
    task automatic step();
        logic [N-1:0] nxt [R];
        nxt = mdl;
        if (rst) begin
            for (int i = 0; i < R; i++) nxt[i] = '0;
        end else if (bus.inr_check) begin
            for (int i = 0; i < R; i++) nxt[i] = N'(i);
        end else if (bus.Reg_Write) begin
            nxt[bus.Reg_write_ad] = bus.Reg_write_data;
        end
        @(posedge clk);
        #1;
        mdl = nxt;
    endtask

    task automatic read2(input string tag, input int a1, input int a2);
        bus.Reg_read_ad_1 = M'(a1);
        bus.Reg_read_ad_2 = M'(a2);
        #1;
        check({tag, "_p1"}, bus.Reg_read_data_1, mdl[a1]);
        check({tag, "_p2"}, bus.Reg_read_data_2, mdl[a2]);
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < R; a++) read2(tag, a, R - 1 - a);
    endtask

    task automatic write(input int ad, input int data);
        bus.Reg_Write      = 1'b1;
        bus.Reg_write_ad   = M'(ad);
        bus.Reg_write_data = N'(data);
        step();
        bus.Reg_Write      = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst                = 1'b1;
        bus.Reg_Write      = 1'b0;
        bus.Reg_write_ad   = '0;
        bus.Reg_write_data = '0;
        bus.Reg_read_ad_1  = '0;
        bus.Reg_read_ad_2  = '0;
        bus.inr_check      = 1'b0;
        for (int i = 0; i < R; i++) mdl[i] = 'x;
        step();
        rst = 1'b0;
        check_all("reset_state");

        // Sequential writes, then combinational read address change.
        write(0, 20);
        write(1, 10);
        write(5, 30);
        read2("seq_wr", 0, 1);
        check("seq_r0_lit", bus.Reg_read_data_1, 16'd20);
        check("seq_r1_lit", bus.Reg_read_data_2, 16'd10);
        bus.Reg_read_ad_1 = 3'd5;
        #1;
        check("seq_r5_comb", bus.Reg_read_data_1, 16'd30);

        // Write-port activity with the enable low must not change anything.
        bus.Reg_write_ad   = 3'd0;
        bus.Reg_write_data = 16'd1;
        for (int k = 0; k < 3; k++) begin
            bus.Reg_write_data = N'(k + 1);
            step();
        end
        read2("wr_disabled", 0, 5);
        check("wr_disabled_lit", bus.Reg_read_data_1, 16'd20);

        // Reset clears all; reset beats a simultaneous write.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("reset_clear");
        rst = 1'b1;
        bus.Reg_Write      = 1'b1;
        bus.Reg_write_ad   = 3'd3;
        bus.Reg_write_data = 16'hFFFF;
        step();
        rst = 1'b0;
        bus.Reg_Write = 1'b0;
        read2("reset_vs_write", 3, 3);
        check("reset_vs_write_lit", bus.Reg_read_data_1, 16'd0);

        // Index-init, then reset beating index-init.
        bus.inr_check = 1'b1;
        step();
        bus.inr_check = 1'b0;
        check_all("inr_check");
        bus.Reg_read_ad_1 = 3'd6;
        #1;
        check("inr_r6_lit", bus.Reg_read_data_1, 16'd6);
        rst = 1'b1;
        bus.inr_check = 1'b1;
        step();
        rst = 1'b0;
        bus.inr_check = 1'b0;
        check_all("reset_vs_inr");

        // Read-during-write returns the old value until the edge.
        write(2, 5);
        bus.Reg_read_ad_1  = 3'd2;
        bus.Reg_read_ad_2  = 3'd2;
        bus.Reg_Write      = 1'b1;
        bus.Reg_write_ad   = 3'd2;
        bus.Reg_write_data = 16'd9;
        #1;
        check("rdw_before", bus.Reg_read_data_1, 16'd5);
        step();
        bus.Reg_Write = 1'b0;
        check("rdw_after", bus.Reg_read_data_1, 16'd9);
        check("rdw_same_port", bus.Reg_read_data_2, bus.Reg_read_data_1);

        // Max address write leaves neighbours alone.
        write(7, 16'hABCD);
        read2("max_addr", 7, 6);
        read2("max_addr_r0", 0, 7);
        check("max_addr_lit", bus.Reg_read_data_2, 16'hABCD);

        // Randomized traffic, checked before and after every edge.
        for (int it = 0; it < 400; it++) begin
            rst                = ($urandom_range(0, 39) == 0);
            bus.inr_check      = ($urandom_range(0, 29) == 0);
            bus.Reg_Write      = 1'($urandom_range(0, 1));
            bus.Reg_write_ad   = M'($urandom);
            bus.Reg_write_data = N'($urandom);
            read2("rnd_pre", int'($urandom_range(0, R - 1)), int'($urandom_range(0, R - 1)));
            step();
            read2("rnd_post", int'(bus.Reg_write_ad), int'($urandom_range(0, R - 1)));
        end
        rst           = 1'b0;
        bus.inr_check = 1'b0;
        bus.Reg_Write = 1'b0;
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
